// File: rtl/aux_uart_pkg.sv
// Shared register offsets and STATUS bit positions for the aux-bus UART register block.
package aux_uart_pkg;

   localparam logic [2:0] REG_DATA   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_PRE_LO = 3'd2;
   localparam logic [2:0] REG_PRE_HI = 3'd3;
   localparam logic [2:0] REG_IRQ_EN = 3'd4;

   localparam int ST_RX_NEMPTY = 0;
   localparam int ST_TX_NFULL  = 1;
   localparam int ST_TX_IDLE   = 2;
   localparam int ST_RX_OVR    = 3;
   localparam int ST_TX_OVF    = 4;
   localparam int ST_IRQ       = 5;

endpackage

// File: rtl/aux_uart_regs_if.sv
// Aux bus between the risc16f84 core (master) and a peripheral register block (slave).
interface aux_uart_regs_if #(parameter int AW = 16);

   logic [AW-1:0] aux_adr_i;
   logic [7:0]    aux_dat_i;
   logic [7:0]    aux_dat_o;
   logic          aux_dat_oe_o;
   logic          aux_we_i;
   logic          aux_re_i;

   modport slave (
      input  aux_adr_i, aux_dat_i, aux_we_i, aux_re_i,
      output aux_dat_o, aux_dat_oe_o
   );

   modport master (
      output aux_adr_i, aux_dat_i, aux_we_i, aux_re_i,
      input  aux_dat_o, aux_dat_oe_o
   );

endinterface

// File: rtl/aux_uart_regs_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/aux_uart_regs.sv
// UART register window on the risc16f84 aux bus: TX/RX FIFOs, status flags, prescale and IRQ.
module aux_uart_regs
   import aux_uart_pkg::*;
#(
   parameter int                         AUX_ADDR_WIDTH = 16,
   parameter logic [AUX_ADDR_WIDTH-1:0]  BASE_ADDR      = 16'hFF00,
   parameter int                         FIFO_AW        = 4,
   parameter logic [15:0]                PRESCALE_RST   = 16'd1
) (
   input  logic        clk,
   input  logic        reset_n,
   aux_uart_regs_if.slave aux,
   output logic [7:0]  tx_tdata_o,
   output logic        tx_tvalid_o,
   input  logic        tx_tready_i,
   input  logic [7:0]  rx_tdata_i,
   input  logic        rx_tvalid_i,
   output logic        rx_tready_o,
   output logic [15:0] prescale_o,
   output logic        irq_o
);

   localparam int FIFO_DEPTH = 1 << FIFO_AW;

   logic             hit;
   logic [2:0]       off;
   logic             wr;
   logic             rd;
   logic [7:0]       rdata;
   logic [7:0]       status;

   logic             tx_push, tx_pop, tx_full, tx_empty;
   logic [FIFO_AW:0] tx_count;
   logic             rx_push, rx_pop, rx_full, rx_empty;
   logic [FIFO_AW:0] rx_count;
   logic [7:0]       rx_head;

   logic             rx_ovr, tx_ovf;
   logic [1:0]       irq_en;
   logic             rx_ovr_set, tx_ovf_set;
   logic             rx_ovr_clr, tx_ovf_clr;

   assign hit = (aux.aux_adr_i[AUX_ADDR_WIDTH-1:3] == BASE_ADDR[AUX_ADDR_WIDTH-1:3]);
   assign off = aux.aux_adr_i[2:0];
   assign wr  = aux.aux_we_i & hit;
   // A simultaneous write takes the cycle; the read still returns data but has no side effect.
   assign rd  = aux.aux_re_i & hit & ~aux.aux_we_i;

   assign tx_push = wr & (off == REG_DATA);
   assign tx_pop  = tx_tvalid_o & tx_tready_i;
   assign rx_push = rx_tvalid_i & rx_tready_o;
   assign rx_pop  = rd & (off == REG_DATA) & ~rx_empty;

   assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
   assign rx_ovr_set = rx_push & rx_full & ~rx_pop;
   assign tx_ovf_clr = wr & (off == REG_STATUS) & aux.aux_dat_i[ST_TX_OVF];
   assign rx_ovr_clr = wr & (off == REG_STATUS) & aux.aux_dat_i[ST_RX_OVR];

   sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (tx_push),
      .din     (aux.aux_dat_i),
      .pop     (tx_pop),
      .dout    (tx_tdata_o),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count)
   );

   sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (rx_push),
      .din     (rx_tdata_i),
      .pop     (rx_pop),
      .dout    (rx_head),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

   assign tx_tvalid_o = ~tx_empty;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_tready_o <= 1'b0;
         rx_ovr      <= 1'b0;
         tx_ovf      <= 1'b0;
         irq_en      <= 2'b00;
         prescale_o  <= PRESCALE_RST;
         irq_o       <= 1'b0;
      end else begin
         rx_tready_o <= 1'b1;
         // Set has priority over a write-one-to-clear in the same cycle.
         if (rx_ovr_set)      rx_ovr <= 1'b1;
         else if (rx_ovr_clr) rx_ovr <= 1'b0;
         if (tx_ovf_set)      tx_ovf <= 1'b1;
         else if (tx_ovf_clr) tx_ovf <= 1'b0;
         if (wr && off == REG_PRE_LO) prescale_o[7:0]  <= aux.aux_dat_i;
         if (wr && off == REG_PRE_HI) prescale_o[15:8] <= aux.aux_dat_i;
         if (wr && off == REG_IRQ_EN) irq_en           <= aux.aux_dat_i[1:0];
         irq_o <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
      end
   end

   always_comb begin
      status               = 8'h00;
      status[ST_RX_NEMPTY] = ~rx_empty;
      status[ST_TX_NFULL]  = ~tx_full;
      status[ST_TX_IDLE]   = tx_empty;
      status[ST_RX_OVR]    = rx_ovr;
      status[ST_TX_OVF]    = tx_ovf;
      status[ST_IRQ]       = irq_o;
   end

   always_comb begin
      rdata = 8'h00;
      if (hit) begin
         case (off)
            REG_DATA:   rdata = rx_empty ? 8'h00 : rx_head;
            REG_STATUS: rdata = status;
            REG_PRE_LO: rdata = prescale_o[7:0];
            REG_PRE_HI: rdata = prescale_o[15:8];
            REG_IRQ_EN: rdata = {6'b0, irq_en};
            default:    rdata = 8'h00;
         endcase
      end
   end

   assign aux.aux_dat_o    = rdata;
   assign aux.aux_dat_oe_o = aux.aux_re_i & hit;

   a_tx_count: assert property (@(posedge clk) disable iff (!reset_n)
                                tx_count <= (FIFO_AW+1)'(FIFO_DEPTH));
   a_rx_count: assert property (@(posedge clk) disable iff (!reset_n)
                                rx_count <= (FIFO_AW+1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_aux_uart_regs.sv
// Directed bench for aux_uart_regs: read data and TX bytes are checked by queue-driven monitors.
module tb_aux_uart_regs;
   import aux_uart_pkg::*;

   localparam logic [15:0] BASE = 16'hFF00;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  tx_tdata;
   logic        tx_tvalid;
   logic        tx_tready;
   logic [7:0]  rx_tdata;
   logic        rx_tvalid;
   logic        rx_tready;
   logic [15:0] prescale;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [7:0] rd_q[$];
   logic [7:0] tx_q[$];

   aux_uart_regs_if #(.AW(16)) aif ();

   aux_uart_regs #(
      .AUX_ADDR_WIDTH (16),
      .BASE_ADDR      (BASE),
      .FIFO_AW        (4),
      .PRESCALE_RST   (16'd1)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .aux         (aif.slave),
      .tx_tdata_o  (tx_tdata),
      .tx_tvalid_o (tx_tvalid),
      .tx_tready_i (tx_tready),
      .rx_tdata_i  (rx_tdata),
      .rx_tvalid_i (rx_tvalid),
      .rx_tready_o (rx_tready),
      .prescale_o  (prescale),
      .irq_o       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Read data monitor
   always @(negedge clk) begin
      if (aif.aux_dat_oe_o) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got 0x%0h expected no read", aif.aux_dat_o);
         end else begin
            check("rd_data", {8'h00, aif.aux_dat_o}, {8'h00, rd_q.pop_front()});
         end
      end
   end

   // TX stream monitor
   always @(negedge clk) begin
      if (tx_tvalid && tx_tready) begin
         if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_tdata);
         end else begin
            check("tx_data", {8'h00, tx_tdata}, {8'h00, tx_q.pop_front()});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   // All bus tasks are entered and left 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_read(input logic [2:0] off, input logic [7:0] exp);
      aif.aux_adr_i = BASE | 16'(off);
      aif.aux_re_i  = 1'b1;
      rd_q.push_back(exp);
      tick();
      aif.aux_re_i  = 1'b0;
   endtask

   task automatic reg_write(input logic [2:0] off, input logic [7:0] dat);
      aif.aux_adr_i = BASE | 16'(off);
      aif.aux_dat_i = dat;
      aif.aux_we_i  = 1'b1;
      tick();
      aif.aux_we_i  = 1'b0;
   endtask

   task automatic rx_send(input logic [7:0] b);
      rx_tdata  = b;
      rx_tvalid = 1'b1;
      tick();
      rx_tvalid = 1'b0;
   endtask

   initial begin
      reset_n       = 1'b0;
      tx_tready     = 1'b0;
      rx_tdata      = 8'h00;
      rx_tvalid     = 1'b0;
      aif.aux_adr_i = 16'h0000;
      aif.aux_dat_i = 8'h00;
      aif.aux_we_i  = 1'b0;
      aif.aux_re_i  = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // 1: reset state
      check("rst_prescale", prescale, 16'h0001);
      check("rst_irq", {15'b0, irq}, 16'h0);
      check("rst_tvalid", {15'b0, tx_tvalid}, 16'h0);
      check("rst_rready", {15'b0, rx_tready}, 16'h0);
      reset_n = 1'b1;
      tick();
      check("rready_up", {15'b0, rx_tready}, 16'h1);
      reg_read(REG_STATUS, 8'h06);
      reg_read(REG_PRE_LO, 8'h01);
      reg_read(REG_PRE_HI, 8'h00);
      reg_read(REG_IRQ_EN, 8'h00);
      reg_read(3'd5, 8'h00);

      // 2: single TX byte
      tx_tready = 1'b1;
      tx_q.push_back(8'h41);
      reg_write(REG_DATA, 8'h41);
      check("tx_valid_next", {15'b0, tx_tvalid}, 16'h1);
      check("tx_tdata_next", {8'h00, tx_tdata}, 16'h0041);
      tick();
      reg_read(REG_STATUS, 8'h06);

      // 3: TX overflow with sink stalled
      tx_tready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) tx_q.push_back(8'h10 + 8'(i));
         reg_write(REG_DATA, 8'h10 + 8'(i));
      end
      reg_read(REG_STATUS, 8'h10);
      tx_tready = 1'b1;
      repeat (20) tick();
      check("tx_drained", 16'(tx_q.size()), 16'h0);
      reg_write(REG_STATUS, 8'h10);
      reg_read(REG_STATUS, 8'h06);

      // 4: RX two bytes then empty read
      rx_send(8'h55);
      rx_send(8'hAA);
      reg_read(REG_DATA, 8'h55);
      reg_read(REG_DATA, 8'hAA);
      reg_read(REG_DATA, 8'h00);
      reg_read(REG_STATUS, 8'h06);

      // 5: RX full, pop-and-push, then overrun
      for (int i = 0; i < 16; i++) rx_send(8'h80 + 8'(i));
      reg_read(REG_STATUS, 8'h07);
      rx_tdata      = 8'h90;
      rx_tvalid     = 1'b1;
      aif.aux_adr_i = BASE | 16'(REG_DATA);
      aif.aux_re_i  = 1'b1;
      rd_q.push_back(8'h80);
      tick();
      rx_tvalid     = 1'b0;
      aif.aux_re_i  = 1'b0;
      reg_read(REG_STATUS, 8'h07);
      rx_send(8'h91);
      reg_read(REG_STATUS, 8'h0F);
      reg_write(REG_STATUS, 8'h08);
      reg_read(REG_STATUS, 8'h07);
      for (int i = 1; i < 17; i++) reg_read(REG_DATA, 8'h80 + 8'(i));
      reg_read(REG_STATUS, 8'h06);

      // prescale and unmapped offsets
      reg_write(REG_PRE_LO, 8'h34);
      check("pre_lo_apply", prescale, 16'h0034 | 16'h0000);
      reg_write(REG_PRE_HI, 8'h12);
      check("pre_hi_apply", prescale, 16'h1234);
      reg_read(REG_PRE_LO, 8'h34);
      reg_read(REG_PRE_HI, 8'h12);
      reg_write(3'd6, 8'hFF);
      reg_read(3'd6, 8'h00);
      reg_write(REG_IRQ_EN, 8'hFD);
      reg_read(REG_IRQ_EN, 8'h01);

      // 6: RX IRQ
      rx_send(8'h33);
      check("irq_latency0", {15'b0, irq}, 16'h0);
      tick();
      check("irq_high", {15'b0, irq}, 16'h1);
      reg_read(REG_STATUS, 8'h27);
      reg_read(REG_DATA, 8'h33);
      check("irq_hold", {15'b0, irq}, 16'h1);
      tick();
      check("irq_low", {15'b0, irq}, 16'h0);

      // reset in the middle of traffic
      tx_tready = 1'b0;
      reg_write(REG_DATA, 8'hA1);
      reg_write(REG_DATA, 8'hA2);
      rx_send(8'h11);
      rx_send(8'h22);
      tick();
      check("pre_rst_irq", {15'b0, irq}, 16'h1);
      reset_n = 1'b0;
      tick();
      check("mid_rst_tvalid", {15'b0, tx_tvalid}, 16'h0);
      check("mid_rst_rready", {15'b0, rx_tready}, 16'h0);
      check("mid_rst_irq", {15'b0, irq}, 16'h0);
      check("mid_rst_prescale", prescale, 16'h0001);
      reset_n   = 1'b1;
      tx_tready = 1'b1;
      tick();
      tick();
      check("post_rst_tvalid", {15'b0, tx_tvalid}, 16'h0);
      check("post_rst_rready", {15'b0, rx_tready}, 16'h1);
      reg_read(REG_STATUS, 8'h06);
      reg_read(REG_IRQ_EN, 8'h00);
      reg_read(REG_DATA, 8'h00);
      tick();

      check("rd_q_empty", 16'(rd_q.size()), 16'h0);
      check("tx_q_empty", 16'(tx_q.size()), 16'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
